// File: rtl/cmp_rs_array.sv
// Reservation station for compare/branch ops: operands wait on ROB tags and snoop the CDB.
// Ready entries issue oldest-first into a single registered result slot.
module cmp_rs_array #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_is_br,
    input  logic [2:0]                   in_cmp_op,
    input  logic [XLEN-1:0]              in_vj,
    input  logic [XLEN-1:0]              in_vk,
    input  logic [TAG_W-1:0]             in_qj,
    input  logic [TAG_W-1:0]             in_qk,
    input  logic [TAG_W-1:0]             in_dest,
    input  logic                         in_br_pred,
    input  logic [XLEN-1:0]              in_pc,
    input  logic [XLEN-1:0]              in_b_imm,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [XLEN-1:0]              cdb_val,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [TAG_W-1:0]             out_tag,
    output logic [XLEN-1:0]              out_val,
    output logic                         out_br_ok,
    output logic [XLEN-1:0]              out_pc_next,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    // Per-entry state; age 0 is the oldest resident entry, ages stay dense 0..count-1.
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [AW-1:0]     age_q    [DEPTH];
    logic [AW-1:0]     age_d    [DEPTH];
    logic              is_br_q  [DEPTH];
    logic              is_br_d  [DEPTH];
    logic [2:0]        op_q     [DEPTH];
    logic [2:0]        op_d     [DEPTH];
    logic [XLEN-1:0]   vj_q     [DEPTH];
    logic [XLEN-1:0]   vj_d     [DEPTH];
    logic [XLEN-1:0]   vk_q     [DEPTH];
    logic [XLEN-1:0]   vk_d     [DEPTH];
    logic [TAG_W-1:0]  qj_q     [DEPTH];
    logic [TAG_W-1:0]  qj_d     [DEPTH];
    logic [TAG_W-1:0]  qk_q     [DEPTH];
    logic [TAG_W-1:0]  qk_d     [DEPTH];
    logic [TAG_W-1:0]  dest_q   [DEPTH];
    logic [TAG_W-1:0]  dest_d   [DEPTH];
    logic              pred_q   [DEPTH];
    logic              pred_d   [DEPTH];
    logic [XLEN-1:0]   pc_q     [DEPTH];
    logic [XLEN-1:0]   pc_d     [DEPTH];
    logic [XLEN-1:0]   imm_q    [DEPTH];
    logic [XLEN-1:0]   imm_d    [DEPTH];

    logic [CW-1:0]     count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic [XLEN-1:0]   out_val_q, out_val_d;
    logic              out_br_ok_q, out_br_ok_d;
    logic [XLEN-1:0]   out_pc_next_q, out_pc_next_d;

    logic              cand_found;
    logic [AW-1:0]     cand_idx;
    logic [AW-1:0]     cand_age;
    logic              free_found;
    logic [AW-1:0]     free_idx;
    logic              do_issue;
    logic              do_alloc;
    logic              res;
    logic [XLEN-1:0]   sel_vj, sel_vk, sel_pc;

    // Oldest ready entry and lowest free slot.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        cand_age   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0) &&
                (!cand_found || (age_q[i] < cand_age))) begin
                cand_found = 1'b1;
                cand_idx   = AW'(i);
                cand_age   = age_q[i];
            end
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = AW'(i);
            end
        end
    end

    assign do_issue = cand_found && (!out_valid_q || out_ready) && !flush;
    assign do_alloc = in_valid && in_ready_q && !flush;

    assign sel_vj = vj_q[cand_idx];
    assign sel_vk = vk_q[cand_idx];
    assign sel_pc = pc_q[cand_idx];

    always_comb begin
        res = 1'b0;
        case (op_q[cand_idx])
            3'b000:  res = (sel_vj == sel_vk);
            3'b001:  res = (sel_vj != sel_vk);
            3'b100:  res = ($signed(sel_vj) <  $signed(sel_vk));
            3'b101:  res = ($signed(sel_vj) >= $signed(sel_vk));
            3'b110:  res = (sel_vj <  sel_vk);
            3'b111:  res = (sel_vj >= sel_vk);
            default: res = 1'b0;
        endcase
    end

    // Entry next-state: CDB capture, age compaction on issue, allocation, flush.
    always_comb begin
        busy_d  = busy_q;
        age_d   = age_q;
        is_br_d = is_br_q;
        op_d    = op_q;
        vj_d    = vj_q;
        vk_d    = vk_q;
        qj_d    = qj_q;
        qk_d    = qk_q;
        dest_d  = dest_q;
        pred_d  = pred_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        count_d = count_q;

        for (int i = 0; i < int'(DEPTH); i++) begin
            if (busy_q[i] && cdb_valid && (qj_q[i] != '0) && (cdb_tag == qj_q[i])) begin
                vj_d[i] = cdb_val;
                qj_d[i] = '0;
            end
            if (busy_q[i] && cdb_valid && (qk_q[i] != '0) && (cdb_tag == qk_q[i])) begin
                vk_d[i] = cdb_val;
                qk_d[i] = '0;
            end
            if (do_issue && busy_q[i] && (age_q[i] > cand_age)) begin
                age_d[i] = age_q[i] - AW'(1);
            end
        end

        if (do_issue) begin
            busy_d[cand_idx] = 1'b0;
        end

        if (do_alloc) begin
            busy_d[free_idx]  = 1'b1;
            age_d[free_idx]   = AW'(count_q) - (do_issue ? AW'(1) : AW'(0));
            is_br_d[free_idx] = in_is_br;
            op_d[free_idx]    = in_cmp_op;
            vj_d[free_idx]    = in_vj;
            vk_d[free_idx]    = in_vk;
            qj_d[free_idx]    = in_qj;
            qk_d[free_idx]    = in_qk;
            dest_d[free_idx]  = in_dest;
            pred_d[free_idx]  = in_br_pred;
            pc_d[free_idx]    = in_pc;
            imm_d[free_idx]   = in_b_imm;
            if (cdb_valid && (in_qj != '0) && (cdb_tag == in_qj)) begin
                vj_d[free_idx] = cdb_val;
                qj_d[free_idx] = '0;
            end
            if (cdb_valid && (in_qk != '0) && (cdb_tag == in_qk)) begin
                vk_d[free_idx] = cdb_val;
                qk_d[free_idx] = '0;
            end
        end

        count_d = count_q + CW'(do_alloc) - CW'(do_issue);

        if (flush) begin
            busy_d  = '0;
            count_d = '0;
        end

        in_ready_d = (count_d < CW'(DEPTH));
    end

    // Result register: loads on issue, empties on handshake, holds under backpressure.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_tag_d     = out_tag_q;
        out_val_d     = out_val_q;
        out_br_ok_d   = out_br_ok_q;
        out_pc_next_d = out_pc_next_q;
        if (do_issue) begin
            out_valid_d   = 1'b1;
            out_tag_d     = dest_q[cand_idx];
            out_val_d     = is_br_q[cand_idx] ? sel_pc : {{(XLEN-1){1'b0}}, res};
            out_br_ok_d   = (pred_q[cand_idx] == res);
            out_pc_next_d = res ? (sel_pc + imm_q[cand_idx]) : (sel_pc + XLEN'(4));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            count_q       <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_tag_q     <= '0;
            out_val_q     <= '0;
            out_br_ok_q   <= 1'b0;
            out_pc_next_q <= '0;
        end else begin
            busy_q        <= busy_d;
            count_q       <= count_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_tag_q     <= out_tag_d;
            out_val_q     <= out_val_d;
            out_br_ok_q   <= out_br_ok_d;
            out_pc_next_q <= out_pc_next_d;
        end
    end

    // Payload storage is qualified by busy, so it needs no reset.
    always_ff @(posedge clk) begin
        age_q   <= age_d;
        is_br_q <= is_br_d;
        op_q    <= op_d;
        vj_q    <= vj_d;
        vk_q    <= vk_d;
        qj_q    <= qj_d;
        qk_q    <= qk_d;
        dest_q  <= dest_d;
        pred_q  <= pred_d;
        pc_q    <= pc_d;
        imm_q   <= imm_d;
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_tag     = out_tag_q;
    assign out_val     = out_val_q;
    assign out_br_ok   = out_br_ok_q;
    assign out_pc_next = out_pc_next_q;
    assign count       = count_q;

endmodule

// File: tb/tb_cmp_rs_array.sv
// Directed bench for cmp_rs_array: compare-op vector table plus multi-cycle ordering/flush sequences.
module tb_cmp_rs_array;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_is_br;
    logic [2:0]        in_cmp_op;
    logic [XLEN-1:0]   in_vj, in_vk;
    logic [TAG_W-1:0]  in_qj, in_qk, in_dest;
    logic              in_br_pred;
    logic [XLEN-1:0]   in_pc, in_b_imm;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [XLEN-1:0]   cdb_val;
    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic [XLEN-1:0]   out_val;
    logic              out_br_ok;
    logic [XLEN-1:0]   out_pc_next;
    logic [CW-1:0]     count;

    cmp_rs_array #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_br(in_is_br), .in_cmp_op(in_cmp_op), .in_vj(in_vj), .in_vk(in_vk),
        .in_qj(in_qj), .in_qk(in_qk), .in_dest(in_dest), .in_br_pred(in_br_pred),
        .in_pc(in_pc), .in_b_imm(in_b_imm),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_val(out_val),
        .out_br_ok(out_br_ok), .out_pc_next(out_pc_next), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_br;
        logic [2:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [3:0]  dest;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] e_val;
        logic        e_ok;
        logic [31:0] e_pcn;
    } vec_t;

    vec_t vecs [9];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic [2:0] op, input logic [31:0] vj,
                         input logic [31:0] vk, input logic [3:0] qj, input logic [3:0] qk,
                         input logic [3:0] dest, input logic pred, input logic [31:0] pc,
                         input logic [31:0] imm);
        in_valid   = 1'b1;
        in_is_br   = br;
        in_cmp_op  = op;
        in_vj      = vj;
        in_vk      = vk;
        in_qj      = qj;
        in_qk      = qk;
        in_dest    = dest;
        in_br_pred = pred;
        in_pc      = pc;
        in_b_imm   = imm;
    endtask

    task automatic idle;
        in_valid = 1'b0;
    endtask

    task automatic cdb(input logic v, input logic [3:0] tag, input logic [31:0] val);
        cdb_valid = v;
        cdb_tag   = tag;
        cdb_val   = val;
    endtask

    initial begin
        //           br    op      vj            vk            dest  pred  pc            imm           e_val         e_ok  e_pcn
        vecs[0] = '{1'b1, 3'b000, 32'h5,        32'h5,        4'd3, 1'b1, 32'h100,      32'h20,       32'h100,      1'b1, 32'h120};
        vecs[1] = '{1'b0, 3'b001, 32'h5,        32'h5,        4'd1, 1'b0, 32'h200,      32'h40,       32'h0,        1'b1, 32'h204};
        vecs[2] = '{1'b0, 3'b100, 32'hFFFFFFFF, 32'h1,        4'd2, 1'b0, 32'h300,      32'h10,       32'h1,        1'b0, 32'h310};
        vecs[3] = '{1'b0, 3'b110, 32'hFFFFFFFF, 32'h1,        4'd4, 1'b1, 32'h300,      32'h10,       32'h0,        1'b0, 32'h304};
        vecs[4] = '{1'b0, 3'b101, 32'h80000000, 32'h0,        4'd5, 1'b0, 32'h10,       32'h8,        32'h0,        1'b1, 32'h14};
        vecs[5] = '{1'b0, 3'b111, 32'h80000000, 32'h0,        4'd6, 1'b1, 32'h10,       32'h8,        32'h1,        1'b1, 32'h18};
        vecs[6] = '{1'b0, 3'b010, 32'h3,        32'h3,        4'd7, 1'b0, 32'h50,       32'h8,        32'h0,        1'b1, 32'h54};
        vecs[7] = '{1'b1, 3'b000, 32'h7,        32'h7,        4'd8, 1'b0, 32'hFFFFFFF0, 32'h20,       32'hFFFFFFF0, 1'b0, 32'h10};
        vecs[8] = '{1'b1, 3'b111, 32'h1,        32'h2,        4'd9, 1'b0, 32'hFFFFFFFE, 32'h100,      32'hFFFFFFFE, 1'b1, 32'h2};

        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        idle();
        drive(1'b0, 3'b000, '0, '0, '0, '0, '0, 1'b0, '0, '0);
        in_valid = 1'b0;
        cdb(1'b0, '0, '0);

        // Reset state
        tick(); tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_val", 64'(out_val), 64'd0);
        chk("rst_out_br_ok", 64'(out_br_ok), 64'd0);
        chk("rst_out_pc_next", 64'(out_pc_next), 64'd0);
        rst = 1'b0;
        tick();

        // Compare-op table: alloc edge, result the following edge, then drained
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].is_br, vecs[i].op, vecs[i].vj, vecs[i].vk, 4'd0, 4'd0,
                  vecs[i].dest, vecs[i].pred, vecs[i].pc, vecs[i].imm);
            tick();
            idle();
            chk($sformatf("vec%0d_valid_alloc", i), 64'(out_valid), 64'd0);
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(vecs[i].dest));
            chk($sformatf("vec%0d_val", i), 64'(out_val), 64'(vecs[i].e_val));
            chk($sformatf("vec%0d_br_ok", i), 64'(out_br_ok), 64'(vecs[i].e_ok));
            chk($sformatf("vec%0d_pc_next", i), 64'(out_pc_next), 64'(vecs[i].e_pcn));
            tick();
            chk($sformatf("vec%0d_drain", i), 64'(out_valid), 64'd0);
        end

        // CDB wakeup two cycles after alloc
        drive(1'b0, 3'b110, 32'h1, 32'h0, 4'd0, 4'd7, 4'd2, 1'b0, 32'h40, 32'h4);
        tick(); idle();
        tick();
        chk("wake_wait", 64'(out_valid), 64'd0);
        cdb(1'b1, 4'd7, 32'hFFFFFFFF);
        tick(); cdb(1'b0, '0, '0);
        chk("wake_capture", 64'(out_valid), 64'd0);
        tick();
        chk("wake_valid", 64'(out_valid), 64'd1);
        chk("wake_tag", 64'(out_tag), 64'd2);
        chk("wake_val", 64'(out_val), 64'd1);
        tick();

        // Same-cycle forward at allocation
        drive(1'b0, 3'b110, 32'h1, 32'h0, 4'd0, 4'd7, 4'd2, 1'b0, 32'h40, 32'h4);
        cdb(1'b1, 4'd7, 32'hFFFFFFFF);
        tick(); idle(); cdb(1'b0, '0, '0);
        chk("fwd_alloc", 64'(out_valid), 64'd0);
        tick();
        chk("fwd_valid", 64'(out_valid), 64'd1);
        chk("fwd_val", 64'(out_val), 64'd1);
        tick();

        // Fill all entries waiting on tag 9, then drain in allocation order
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1'b0, 3'b000, 32'h0, 32'h0, 4'd9, 4'd0, 4'(i + 1), 1'b0, 32'h0, 32'h0);
            tick();
        end
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_in_ready", 64'(in_ready), 64'd0);
        drive(1'b0, 3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 4'd15, 1'b0, 32'h0, 32'h0);
        tick(); idle();
        chk("full_ignore_count", 64'(count), 64'(DEPTH));
        chk("full_no_issue", 64'(out_valid), 64'd0);
        cdb(1'b1, 4'd9, 32'h0);
        tick(); cdb(1'b0, '0, '0);
        chk("full_capture_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            tick();
            chk($sformatf("drain%0d_tag", i), 64'(out_tag), 64'(i + 1));
            chk($sformatf("drain%0d_count", i), 64'(count), 64'(int'(DEPTH) - 1 - i));
            chk($sformatf("drain%0d_in_ready", i), 64'(in_ready), 64'd1);
        end
        tick();
        chk("drain_done", 64'(out_valid), 64'd0);

        // Backpressure: first result holds, second waits
        out_ready = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 4'd5, 1'b0, 32'h0, 32'h0);
        tick();
        chk("bp_count1", 64'(count), 64'd1);
        drive(1'b0, 3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 4'd6, 1'b0, 32'h0, 32'h0);
        tick(); idle();
        chk("bp_first_tag", 64'(out_tag), 64'd5);
        chk("bp_alloc_issue_count", 64'(count), 64'd1);
        tick(); tick();
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_tag", 64'(out_tag), 64'd5);
        chk("bp_hold_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_second_tag", 64'(out_tag), 64'd6);
        chk("bp_second_valid", 64'(out_valid), 64'd1);
        tick();
        chk("bp_drop", 64'(out_valid), 64'd0);

        // Flush with busy entries and pending result
        out_ready = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 4'd1, 1'b0, 32'h0, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'b000, 32'h0, 32'h0, 4'd9, 4'd0, 4'(i + 2), 1'b0, 32'h0, 32'h0);
            tick();
        end
        chk("fl_pre_count", 64'(count), 64'd3);
        chk("fl_pre_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 4'd12, 1'b0, 32'h0, 32'h0);
        cdb(1'b1, 4'd9, 32'h0);
        tick();
        flush = 1'b0; idle(); cdb(1'b0, '0, '0);
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("fl_after_valid", 64'(out_valid), 64'd0);
        chk("fl_after_count", 64'(count), 64'd0);
        out_ready = 1'b1;

        // Reused slot 0 is younger than resident slots 1,2
        drive(1'b0, 3'b000, 32'h0, 32'h0, 4'd5, 4'd0, 4'd1, 1'b0, 32'h0, 32'h0);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0, 4'd6, 4'd0, 4'd2, 1'b0, 32'h0, 32'h0);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0, 4'd6, 4'd0, 4'd3, 1'b0, 32'h0, 32'h0);
        tick(); idle();
        cdb(1'b1, 4'd5, 32'h0);
        tick(); cdb(1'b0, '0, '0);
        tick();
        chk("age_slot0_tag", 64'(out_tag), 64'd1);
        chk("age_slot0_count", 64'(count), 64'd2);
        drive(1'b0, 3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 4'd4, 1'b0, 32'h0, 32'h0);
        cdb(1'b1, 4'd6, 32'h0);
        tick(); idle(); cdb(1'b0, '0, '0);
        chk("age_realloc_valid", 64'(out_valid), 64'd0);
        chk("age_realloc_count", 64'(count), 64'd3);
        tick();
        chk("age_first", 64'(out_tag), 64'd2);
        tick();
        chk("age_second", 64'(out_tag), 64'd3);
        tick();
        chk("age_third", 64'(out_tag), 64'd4);
        tick();
        chk("age_done", 64'(out_valid), 64'd0);

        // Reset mid-operation beats flush and discards a pending result
        out_ready = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 4'd7, 1'b0, 32'h0, 32'h0);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0, 4'd9, 4'd0, 4'd8, 1'b0, 32'h0, 32'h0);
        tick();
        chk("mr_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1; flush = 1'b1;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 4'd10, 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b0; flush = 1'b0; idle();
        chk("mr_count", 64'(count), 64'd0);
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_tag", 64'(out_tag), 64'd0);
        chk("mr_val", 64'(out_val), 64'd0);
        chk("mr_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        cdb(1'b1, 4'd9, 32'h0);
        tick(); cdb(1'b0, '0, '0);
        tick();
        chk("mr_after_valid", 64'(out_valid), 64'd0);
        chk("mr_after_count", 64'(count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
